ir_queue: RTL and testbench
===========================

IR_QUEUE -- requirements
Module: ir_queue

Interface
REQ-001 Parameter WIDTH, default 32, instruction word width in bits.
REQ-002 Parameter DEPTH, default 4, entry count; power of two, >= 2.
REQ-003 CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 RST  input  1  reset, synchronous and active-high.
REQ-005 IS_out  input  WIDTH  instruction word from instruction memory.
REQ-006 IRWre  input  1  push strobe; IS_out is written when accepted.
REQ-007 IRRd  input  1  pop strobe; head entry is consumed when accepted.
REQ-008 Flush  input  1  discard all entries; present only with IR_FLUSH_EN.
REQ-009 Instruction  output  WIDTH  head entry; all-zero when empty.
REQ-010 valid  output  1  high when count > 0.
REQ-011 full  output  1  high when count == DEPTH.
REQ-012 count  output  $clog2(DEPTH+1)  current occupancy.
REQ-013 drop_err  output  1  sticky flag: a push was discarded.

Function
REQ-014 The block SHALL be a circular FIFO with read pointer, write pointer, and count registers; pointers wrap from DEPTH-1 to 0.
REQ-015 A push SHALL be accepted when IRWre=1 and (full=0 or an accepted pop occurs in the same cycle).
REQ-016 A pop SHALL be accepted when IRRd=1 and valid=1; a pop while empty SHALL be ignored with no state change.
REQ-017 A push while full without a simultaneous pop SHALL be discarded and SHALL set drop_err.
REQ-018 Simultaneous accepted push and pop SHALL leave count unchanged and advance both pointers.
REQ-019 Simultaneous push and pop while empty SHALL discard the pop and accept the push; count becomes 1.
REQ-020 An accepted word SHALL appear on Instruction one cycle after its push edge if the queue was empty; there is no same-cycle bypass.
REQ-021 Instruction SHALL be driven combinationally from the head storage entry, gated to zero when valid=0.
REQ-022 valid, full, and count SHALL be derived from registered state only, never from the current-cycle strobes.
REQ-023 Instruction SHALL hold its value across cycles with no accepted pop, matching the hold semantics of the single-entry IR.

Reset
REQ-024 When RST=1 at a rising edge, pointers, count, and drop_err SHALL clear to 0; storage contents are not cleared.
REQ-025 RST SHALL take priority over Flush, IRWre, and IRRd in the same cycle; strobes in that cycle SHALL be ignored.
REQ-026 After reset: Instruction=0, valid=0, full=0, count=0, drop_err=0.

Configuration
REQ-027 Macro IR_FLUSH_EN defined: the Flush port SHALL exist, and Flush=1 SHALL clear pointers and count at the edge, with priority over push and pop; drop_err SHALL be unaffected.
REQ-028 Macro IR_FLUSH_EN undefined: the Flush port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-029 Package ir_pkg SHALL hold IR_WIDTH_DEF=32 and IR_DEPTH_DEF=4, and the block's parameter defaults SHALL use these constants.
REQ-030 Storage SHALL be in sub-module ir_queue_mem: 1 write port and 1 asynchronous read port, WIDTH x DEPTH.

Verification
REQ-031 Reset, then push 0x20010005 -> next cycle valid=1, count=1, Instruction=0x20010005; pop -> next cycle valid=0, Instruction=0.
REQ-032 DEPTH=4: push 0x11, 0x22, 0x33, 0x44, 0x55 on consecutive cycles -> full=1, count=4, drop_err=1; four pops return 0x11..0x44 in order.
REQ-033 Full queue, push 0x66 with pop in the same cycle -> count stays 4; head becomes 0x22; 0x66 is read out after 0x44; drop_err unchanged.
REQ-034 Empty queue, IRWre=1 and IRRd=1 in one cycle with IS_out=0xABCD0000 -> count=1, Instruction=0xABCD0000.
REQ-035 With IR_FLUSH_EN, 3 entries plus Flush=1 and IRWre=1 in the same cycle -> count=0, valid=0; drop_err is kept as before.
REQ-036 RST=1 with IRWre=1 mid-fill -> all outputs at reset values next cycle; 8 push/pop cycles exercise pointer wrap with correct data order.

Source files
------------

// File: rtl/ir_pkg.sv
// Shared defaults for the instruction-register queue.
package ir_pkg;
  localparam int IR_WIDTH_DEF = 32;
  localparam int IR_DEPTH_DEF = 4;
endpackage

// File: rtl/ir_queue_mem.sv
// Storage array for ir_queue: one synchronous write port, one asynchronous read port.
// Contents are never reset; occupancy tracking lives in the parent.
module ir_queue_mem #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ir_queue.sv
// Circular instruction queue; head visible one cycle after push, no bypass; full push without pop is dropped (sticky drop_err).
// Optional Flush port enabled by macro IR_FLUSH_EN.
module ir_queue
  import ir_pkg::*;
#(
  parameter int WIDTH = IR_WIDTH_DEF,
  parameter int DEPTH = IR_DEPTH_DEF
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [WIDTH-1:0]           IS_out,
  input  logic                       IRWre,
  input  logic                       IRRd,
`ifdef IR_FLUSH_EN
  input  logic                       Flush,
`endif
  output logic [WIDTH-1:0]           Instruction,
  output logic                       valid,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       drop_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [WIDTH-1:0] head;
  logic             pop_ok;
  logic             push_ok;
  logic             flush_now;

`ifdef IR_FLUSH_EN
  assign flush_now = Flush;
`else
  assign flush_now = 1'b0;
`endif

  // Status comes from registered count only, never from this cycle's strobes.
  assign valid   = (count != '0);
  assign full    = (count == CW'(DEPTH));
  assign pop_ok  = IRRd & valid;
  assign push_ok = IRWre & (~full | pop_ok);

  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      drop_err <= 1'b0;
    end else if (flush_now) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      if (push_ok && !pop_ok)      count <= count + CW'(1);
      else if (pop_ok && !push_ok) count <= count - CW'(1);
      if (IRWre && !push_ok) drop_err <= 1'b1;
    end
  end

  ir_queue_mem #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_mem (
    .clk  (CLK),
    .we   (push_ok & ~RST & ~flush_now),
    .waddr(wr_ptr),
    .wdata(IS_out),
    .raddr(rd_ptr),
    .rdata(head)
  );

  assign Instruction = valid ? head : '0;

endmodule

// File: tb/tb_ir_queue.sv
// Bench for ir_queue: queue-based reference model checked every cycle, plus literal spot checks.
module tb_ir_queue;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  logic             CLK;
  logic             RST;
  logic [WIDTH-1:0] IS_out;
  logic             IRWre;
  logic             IRRd;
  logic             Flush;
  logic [WIDTH-1:0] Instruction;
  logic             valid;
  logic             full;
  logic [2:0]       count;
  logic             drop_err;

  int checks = 0;
  int errors = 0;
  bit checking = 0;

  logic [WIDTH-1:0] mq[$];
  bit               m_drop;

  ir_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .IS_out     (IS_out),
    .IRWre      (IRWre),
    .IRRd       (IRRd),
`ifdef IR_FLUSH_EN
    .Flush      (Flush),
`endif
    .Instruction(Instruction),
    .valid      (valid),
    .full       (full),
    .count      (count),
    .drop_err   (drop_err)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a FIFO of words with the acceptance rules applied at each edge.
  always @(posedge CLK) begin
    bit do_pop;
    bit do_push;
    if (RST) begin
      mq.delete();
      m_drop = 1'b0;
    end else if (Flush === 1'b1) begin
      mq.delete();
    end else begin
      do_pop  = IRRd && (mq.size() > 0);
      do_push = IRWre && ((mq.size() < DEPTH) || do_pop);
      if (IRWre && !do_push) m_drop = 1'b1;
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back(IS_out);
    end
  end

  always @(negedge CLK) begin
    if (checking) begin
      chk("model_instr", Instruction, (mq.size() > 0) ? mq[0] : 32'h0);
      chk("model_valid", {31'b0, valid}, {31'b0, mq.size() > 0});
      chk("model_full",  {31'b0, full},  {31'b0, mq.size() == DEPTH});
      chk("model_count", {29'b0, count}, 32'(mq.size()));
      chk("model_drop",  {31'b0, drop_err}, {31'b0, m_drop});
    end
  end

  // Apply inputs at a falling edge, return at the next falling edge.
  task automatic drive(input logic we, input logic rd, input logic [31:0] d);
    IRWre  = we;
    IRRd   = rd;
    IS_out = d;
    @(negedge CLK);
    IRWre = 1'b0;
    IRRd  = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_instr"}, Instruction, 32'h0);
    chk({tag, "_valid"}, {31'b0, valid}, 32'h0);
    chk({tag, "_full"},  {31'b0, full}, 32'h0);
    chk({tag, "_count"}, {29'b0, count}, 32'h0);
    chk({tag, "_drop"},  {31'b0, drop_err}, 32'h0);
  endtask

  initial begin
    logic [31:0] w;
    RST = 1'b1; IRWre = 1'b0; IRRd = 1'b0; IS_out = '0; Flush = 1'b0;
    @(negedge CLK);
    drive(1'b1, 1'b1, 32'hDEAD_BEEF);   // strobes under reset are ignored
    chk_reset_state("reset");
    RST = 1'b0;
    checking = 1'b1;

    // Single push then pop
    drive(1'b1, 1'b0, 32'h2001_0005);
    chk("p1_valid", {31'b0, valid}, 32'h1);
    chk("p1_count", {29'b0, count}, 32'h1);
    chk("p1_instr", Instruction, 32'h2001_0005);
    drive(1'b0, 1'b1, 32'h0);
    chk("p1_pop_valid", {31'b0, valid}, 32'h0);
    chk("p1_pop_instr", Instruction, 32'h0);

    // Pop while empty is ignored
    drive(1'b0, 1'b1, 32'h0);
    chk("empty_pop_count", {29'b0, count}, 32'h0);

    // Overfill: fifth push dropped
    for (int i = 1; i <= 5; i++) drive(1'b1, 1'b0, 32'h11 * i);
    chk("fill_full",  {31'b0, full}, 32'h1);
    chk("fill_count", {29'b0, count}, 32'h4);
    chk("fill_drop",  {31'b0, drop_err}, 32'h1);
    for (int i = 1; i <= 4; i++) begin
      w = 32'h11 * i;
      chk("drain_order", Instruction, w);
      drive(1'b0, 1'b1, 32'h0);
    end
    chk("drain_empty", {29'b0, count}, 32'h0);

    // Push+pop on a full queue
    for (int i = 1; i <= 4; i++) drive(1'b1, 1'b0, 32'h11 * i);
    drive(1'b1, 1'b1, 32'h66);
    chk("pp_count", {29'b0, count}, 32'h4);
    chk("pp_head",  Instruction, 32'h22);
    chk("pp_drop",  {31'b0, drop_err}, 32'h1);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 32'h0);

    // Push+pop on an empty queue
    drive(1'b1, 1'b1, 32'hABCD_0000);
    chk("ep_count", {29'b0, count}, 32'h1);
    chk("ep_instr", Instruction, 32'hABCD_0000);
    drive(1'b0, 1'b1, 32'h0);

`ifdef IR_FLUSH_EN
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 32'hF0 + i);
    Flush = 1'b1;
    drive(1'b1, 1'b0, 32'h77);
    Flush = 1'b0;
    chk("flush_count", {29'b0, count}, 32'h0);
    chk("flush_valid", {31'b0, valid}, 32'h0);
    chk("flush_drop",  {31'b0, drop_err}, 32'h1);
`endif

    // Reset mid-fill with a push in the same cycle
    drive(1'b1, 1'b0, 32'hC0);
    drive(1'b1, 1'b0, 32'hC1);
    RST = 1'b1;
    drive(1'b1, 1'b0, 32'hC2);
    RST = 1'b0;
    chk_reset_state("midrst");

    // Pointer wrap: steady push+pop with two entries in flight
    drive(1'b1, 1'b0, 32'hA0);
    drive(1'b1, 1'b0, 32'hA1);
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, 32'hB0 + i);
    chk("wrap_count", {29'b0, count}, 32'h2);
    chk("wrap_head",  Instruction, 32'hB6);
    drive(1'b0, 1'b1, 32'h0);
    chk("wrap_next",  Instruction, 32'hB7);
    drive(1'b0, 1'b1, 32'h0);
    chk("wrap_empty", {31'b0, valid}, 32'h0);

    repeat (2) @(negedge CLK);
    checking = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
